gate_op_arbiter: RTL

//  Shares one registered bitwise logic-evaluation unit (AND/OR/XOR/NAND) among
//  N requesters. A round-robin arbiter picks one pending request, captures its

---
 rtl/gate_op_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter in front of one shared, registered bitwise gate unit.
// The winner's operands are captured, evaluated for EXEC_CYCLES clocks, then returned with a pulse.
module gate_op_arbiter #(
  parameter int unsigned N           = 4,
  parameter int unsigned W           = 8,
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [2*N-1:0]   op,
  input  logic [W*N-1:0]   a_in,
  input  logic [W*N-1:0]   b_in,
  output logic [N-1:0]     gnt,
  output logic             busy,
  output logic [W-1:0]     res,
  output logic [N-1:0]     res_valid
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(EXEC_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(N - 1);

  typedef enum logic [0:0] {StIdle, StExec} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [W-1:0]    res_q, res_d;
  logic [N-1:0]    res_valid_q, res_valid_d;

  logic [1:0]      op_arr [N];
  logic [W-1:0]    a_arr  [N];
  logic [W-1:0]    b_arr  [N];

  logic            sel_found;
  logic [IdxW-1:0] sel_idx;

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign op_arr[g] = op[2*g +: 2];
    assign a_arr[g]  = a_in[W*g +: W];
    assign b_arr[g]  = b_in[W*g +: W];
  end

  function automatic logic [W-1:0] gate_eval(input logic [1:0] f, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    logic [W-1:0] r;
    unique case (f)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = a ^ b;
      default: r = ~(a & b);
    endcase
    return r;
  endfunction

  // Circular search starting just after the previous winner.
  always_comb begin
    int unsigned cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (int'(last_q) + k) % N;
      if (!sel_found && req[cand[IdxW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = '0;
    res_d       = res_q;
    res_valid_d = '0;
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          op_d           = op_arr[sel_idx];
          a_d            = a_arr[sel_idx];
          b_d            = b_arr[sel_idx];
          last_d         = sel_idx;
          gnt_d[sel_idx] = 1'b1;
          cnt_d          = '0;
          state_d        = StExec;
        end
      end
      StExec: begin
        if (cnt_q == CntLast) begin
          res_d               = gate_eval(op_q, a_q, b_q);
          res_valid_d[last_q] = 1'b1;
          state_d             = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= IdxLast;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      res_q       <= '0;
      res_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy      = (state_q == StExec);
  assign gnt       = gnt_q;
  assign res       = res_q;
  assign res_valid = res_valid_q;

endmodule
